game_timer: RTL and testbench
=============================

# game_timer

Parametrised countdown timer for the game datapath. It counts a registered seconds value down once per 1 Hz enable pulse and supports start, pause, load, bonus-time add and forced loss. It raises a warning flag near the end and both a sticky expired flag and a one-cycle expire pulse. It sits between the 1 Hz enable generator and the score/display logic, and generalises the fixed 59-second, 8-bit countdown.

## Interface
Parameters:
- WIDTH, 8, bit width of the count; MAX = 2^WIDTH-1
- INIT, 59, count and reload value after reset
- WARN_LEVEL, 10, warn asserts when 0 < count ≤ WARN_LEVEL while running
- AUTO_RELOAD, 0, 0 = one-shot (stop at 0), 1 = reload and keep running on expiry

Ports:
- clk  in  1  system clock; every register is on its rising edge
- rst  in  1  synchronous, active-low reset
- tick  in  1  1 Hz enable, one clk cycle wide
- start  in  1  pulse; arm or re-arm the timer
- pause  in  1  level; freezes the count while high
- load  in  1  pulse; latch load_val as count and reload value
- load_val  in  WIDTH  value for load
- add  in  1  pulse; bonus time
- add_val  in  WIDTH  bonus amount
- lose  in  1  pulse; force immediate expiry
- seconds  out  WIDTH  current count
- running  out  1  high in RUN
- warn  out  1  low-time flag
- expired  out  1  sticky expiry flag
- expire_pulse  out  1  one-cycle pulse on each expiry

## Operation
States are IDLE, RUN, PAUSED and EXPIRED.

Reset (rst = 0 at a clk edge):
- state → IDLE; count and reload → INIT.
- running, warn, expired and expire_pulse all → 0.

Priority within a cycle: lose > load > start > (pause, add, tick).

IDLE:
- load: count and reload ← load_val.
- start: go to RUN. If count = 0, go directly to EXPIRED and pulse expire_pulse.

RUN:
- pause = 1: go to PAUSED. A tick in the same cycle is ignored.
- Otherwise next = sat(count + (add ? add_val : 0)) − (tick ? 1 : 0).
  - The sum uses a WIDTH+1-bit intermediate and saturates at MAX before the decrement.
- If next = 0 and tick = 1, the timer expires:
  - One-shot: count ← 0, state → EXPIRED, expired ← 1, expire_pulse ← 1.
  - AUTO_RELOAD: count ← reload, state stays RUN, expire_pulse ← 1, expired unchanged.
- load is ignored.

PAUSED:
- tick is ignored.
- add applies with saturation.
- pause = 0: return to RUN.
- load is ignored.

EXPIRED:
- count held at 0.
- load: reload ← load_val only; count stays 0.
- start: count ← reload, expired ← 0, state → RUN. If reload = 0, expire again instead.

lose:
- In IDLE, RUN or PAUSED: count ← 0, state → EXPIRED, expired ← 1, expire_pulse ← 1, regardless of AUTO_RELOAD.
- In EXPIRED: no effect and no pulse.

Flags:
- warn = (state == RUN) && count ≠ 0 && count ≤ WARN_LEVEL; registered.
- running = (state == RUN); registered.

## Timing
- All outputs are registered. A tick sampled at edge n shows on seconds after edge n.
- expire_pulse is high for exactly the one cycle after the expiring edge.
- expired rises in the same cycle as expire_pulse.
- warn and running update in the same cycle as seconds.
- start → running = 1 one cycle later. The first decrement happens on the next tick after that.
- Reset mid-run takes effect at the next edge and overrides every other input.
- Back-to-back ticks on consecutive cycles are legal; each decrements once.

## Structure
- Package game_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, EXPIRED);
  - the localparam MAX derivation helper;
  - AUTO_RELOAD mode constants (MODE_ONESHOT, MODE_RELOAD).
- Sub-module sat_addsub computes sat(a + b) − dec on WIDTH+1 bits, clamped to [0, MAX].
  - It is purely combinational and unit-tested separately.

## Test plan
- Reset, start, then 59 ticks: seconds goes 59→0; expire_pulse fires once on the 59th tick; expired = 1; warn is high for counts 10..1 only.
- load_val = 5 in IDLE, then start; pause for 3 ticks, release, add_val = 3, then ticks: seconds reads 5 (held), then 8, 7, …; expiry after 8 further ticks.
- WIDTH = 8, count = 250, add_val = 20 with a simultaneous tick: seconds = 254 (saturated to 255, then −1).
- AUTO_RELOAD = 1, INIT = 3, run 7 ticks: seconds goes 3, 2, 1, 3, 2, 1, 3; expire_pulse twice; expired stays 0.
- lose at count 30: next cycle seconds = 0 and expired = 1 with one pulse. A second lose gives no further pulse. start then reloads 59.
- rst = 0 asserted mid-RUN at count 17, held one edge: seconds = 59, state IDLE, all flags 0; ticks ignored until start.

Source files
------------

// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared types and constants for the game countdown timer
// Contents: state_t (IDLE, RUN, PAUSED, EXPIRED), max_of() all-ones helper,
//           MODE_ONESHOT / MODE_RELOAD values for the AUTO_RELOAD parameter.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_RELOAD  = 1;

  // Largest value representable in 'width' bits (2^width - 1).
  function automatic int unsigned max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// rtl/game_timer_if.sv - control/status bundle between game logic and game_timer
// master: drives tick, start, pause, load/load_val, add/add_val, lose;
//         observes seconds, running, warn, expired, expire_pulse.
// slave:  the timer side, directions reversed.
interface game_timer_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             start;
  logic             pause;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             add;
  logic [WIDTH-1:0] add_val;
  logic             lose;
  logic [WIDTH-1:0] seconds;
  logic             running;
  logic             warn;
  logic             expired;
  logic             expire_pulse;

  modport master (
    output tick, start, pause, load, load_val, add, add_val, lose,
    input  seconds, running, warn, expired, expire_pulse
  );

  modport slave (
    input  tick, start, pause, load, load_val, add, add_val, lose,
    output seconds, running, warn, expired, expire_pulse
  );
endinterface

// File: rtl/game_timer_sat_addsub.sv
// rtl/game_timer_sat_addsub.sv - combinational sat(a + b) - dec, clamped to [0, MAX]
// Ports: a, b (WIDTH) operands; dec (1) subtract one after saturation; y (WIDTH) result.
module sat_addsub
  import game_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dec,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;

  always_comb begin
    // The carry bit of the WIDTH+1-bit sum flags overflow past MAX.
    sum = {1'b0, a} + {1'b0, b};
    sat = sum[WIDTH] ? MAX : sum[WIDTH-1:0];
    // Decrementing zero stays at zero rather than wrapping.
    if (dec && (sat == '0)) begin
      y = '0;
    end else begin
      y = sat - WIDTH'(dec);
    end
  end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - parametrised countdown timer with pause, load, bonus add and forced loss
// Ports: clk (1) rising-edge clock; rst (1) synchronous active-low reset;
//        bus (game_timer_if.slave) controls in, seconds/running/warn/expired/expire_pulse out.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT        = 59,
  parameter int WARN_LEVEL  = 10,
  parameter int AUTO_RELOAD = MODE_ONESHOT
) (
  input  logic         clk,
  input  logic         rst,
  game_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] WARN_V = WIDTH'(WARN_LEVEL);

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             expired, expired_n;
  logic             pulse, pulse_n;
  logic             warn, warn_n;
  logic             running, running_n;

  logic [WIDTH-1:0] add_amt;
  logic             dec;
  logic [WIDTH-1:0] sum_val;

  // Bonus applies in RUN and PAUSED; the decrement only when running unpaused.
  assign add_amt = bus.add ? bus.add_val : '0;
  assign dec     = (state == RUN) && !bus.pause && bus.tick;

  sat_addsub #(.WIDTH(WIDTH)) u_sat_addsub (
    .a   (count),
    .b   (add_amt),
    .dec (dec),
    .y   (sum_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= INIT_V;
      reload  <= INIT_V;
      expired <= 1'b0;
      pulse   <= 1'b0;
      warn    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      reload  <= reload_n;
      expired <= expired_n;
      pulse   <= pulse_n;
      warn    <= warn_n;
      running <= running_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    expired_n = expired;
    pulse_n   = 1'b0;

    if (bus.lose && (state != EXPIRED)) begin
      state_n   = EXPIRED;
      count_n   = '0;
      expired_n = 1'b1;
      pulse_n   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            count_n  = bus.load_val;
            reload_n = bus.load_val;
          end else if (bus.start) begin
            if (count == '0) begin
              state_n   = EXPIRED;
              expired_n = 1'b1;
              pulse_n   = 1'b1;
            end else begin
              state_n = RUN;
            end
          end
        end

        RUN: begin
          if (bus.pause) begin
            // dec is already forced low here, so only a bonus can change the count.
            state_n = PAUSED;
            count_n = sum_val;
          end else if (bus.tick && (sum_val == '0)) begin
            pulse_n = 1'b1;
            if (AUTO_RELOAD == MODE_RELOAD) begin
              count_n = reload;
            end else begin
              state_n   = EXPIRED;
              count_n   = '0;
              expired_n = 1'b1;
            end
          end else begin
            count_n = sum_val;
          end
        end

        PAUSED: begin
          count_n = sum_val;
          if (!bus.pause) begin
            state_n = RUN;
          end
        end

        EXPIRED: begin
          count_n = '0;
          if (bus.load) begin
            reload_n = bus.load_val;
          end else if (bus.start) begin
            if (reload == '0) begin
              expired_n = 1'b1;
              pulse_n   = 1'b1;
            end else begin
              state_n   = RUN;
              count_n   = reload;
              expired_n = 1'b0;
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // Flags are derived from next-state values so they line up with seconds.
    running_n = (state_n == RUN);
    warn_n    = (state_n == RUN) && (count_n != '0) && (count_n <= WARN_V);
  end

  assign bus.seconds      = count;
  assign bus.running      = running;
  assign bus.warn         = warn;
  assign bus.expired      = expired;
  assign bus.expire_pulse = pulse;

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - directed self-checking bench for game_timer and sat_addsub
module tb_game_timer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   pulses;

  game_timer_if #(.WIDTH(8)) a_if ();
  game_timer_if #(.WIDTH(8)) b_if ();

  game_timer #(.WIDTH(8), .INIT(59), .WARN_LEVEL(10), .AUTO_RELOAD(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  game_timer #(.WIDTH(8), .INIT(3), .WARN_LEVEL(10), .AUTO_RELOAD(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  logic [7:0] sa_a, sa_b, sa_y;
  logic       sa_dec;

  sat_addsub #(.WIDTH(8)) dut_sat (
    .a   (sa_a),
    .b   (sa_b),
    .dec (sa_dec),
    .y   (sa_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic flags_a(input string tag, input int sec, input bit run, input bit wrn,
                         input bit exp, input bit pls);
    check({tag, ".seconds"}, 32'(a_if.seconds), 32'(sec));
    check({tag, ".running"}, 32'(a_if.running), 32'(run));
    check({tag, ".warn"}, 32'(a_if.warn), 32'(wrn));
    check({tag, ".expired"}, 32'(a_if.expired), 32'(exp));
    check({tag, ".pulse"}, 32'(a_if.expire_pulse), 32'(pls));
  endtask

  initial begin
    int b_seq[7];
    errors = 0;
    checks = 0;
    b_seq  = '{2, 1, 3, 2, 1, 3, 2};

    {a_if.tick, a_if.start, a_if.pause, a_if.load, a_if.add, a_if.lose} = '0;
    {b_if.tick, b_if.start, b_if.pause, b_if.load, b_if.add, b_if.lose} = '0;
    a_if.load_val = '0; a_if.add_val = '0;
    b_if.load_val = '0; b_if.add_val = '0;

    // sat_addsub unit vectors
    sa_a = 8'd250; sa_b = 8'd20; sa_dec = 1'b1; #1; check("sat.250+20-1", 32'(sa_y), 32'd254);
    sa_a = 8'd0;   sa_b = 8'd0;  sa_dec = 1'b1; #1; check("sat.0-1", 32'(sa_y), 32'd0);
    sa_a = 8'd255; sa_b = 8'd0;  sa_dec = 1'b0; #1; check("sat.255", 32'(sa_y), 32'd255);
    sa_a = 8'd3;   sa_b = 8'd4;  sa_dec = 1'b1; #1; check("sat.3+4-1", 32'(sa_y), 32'd6);

    // Reset state
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    flags_a("reset", 59, 0, 0, 0, 0);
    check("reset_b.seconds", 32'(b_if.seconds), 32'd3);

    // Auto-reload instance: 3,2,1,3,2,1,3 pattern, two pulses, expired stays 0
    b_if.start = 1'b1; cycle(); b_if.start = 1'b0;
    check("ar.start.seconds", 32'(b_if.seconds), 32'd3);
    check("ar.start.running", 32'(b_if.running), 32'd1);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      b_if.tick = 1'b1; cycle(); b_if.tick = 1'b0;
      check($sformatf("ar.tick%0d.seconds", i + 1), 32'(b_if.seconds), 32'(b_seq[i]));
      check($sformatf("ar.tick%0d.pulse", i + 1), 32'(b_if.expire_pulse),
            32'((i == 2) || (i == 5)));
      check($sformatf("ar.tick%0d.expired", i + 1), 32'(b_if.expired), 32'd0);
      pulses += int'(b_if.expire_pulse);
    end
    check("ar.pulse_count", 32'(pulses), 32'd2);

    // Full 59-second countdown
    a_if.start = 1'b1; cycle(); a_if.start = 1'b0;
    flags_a("t1.start", 59, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= 59; i++) begin
      a_if.tick = 1'b1; cycle(); a_if.tick = 1'b0;
      flags_a($sformatf("t1.tick%0d", i), 59 - i, i != 59,
              (59 - i >= 1) && (59 - i <= 10), i == 59, i == 59);
      pulses += int'(a_if.expire_pulse);
    end
    check("t1.pulse_count", 32'(pulses), 32'd1);
    cycle();
    flags_a("t1.after", 0, 0, 0, 1, 0);

    // Load 5, pause through ticks, bonus 3, count out
    do_reset();
    a_if.load = 1'b1; a_if.load_val = 8'd5; cycle(); a_if.load = 1'b0;
    flags_a("t2.load", 5, 0, 0, 0, 0);
    a_if.start = 1'b1; cycle(); a_if.start = 1'b0;
    flags_a("t2.start", 5, 1, 1, 0, 0);
    a_if.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.tick = 1'b1; cycle(); a_if.tick = 1'b0;
      flags_a($sformatf("t2.paused%0d", i), 5, 0, 0, 0, 0);
    end
    a_if.pause = 1'b0; cycle();
    flags_a("t2.resume", 5, 1, 1, 0, 0);
    a_if.add = 1'b1; a_if.add_val = 8'd3; cycle(); a_if.add = 1'b0;
    flags_a("t2.add", 8, 1, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      a_if.tick = 1'b1; cycle(); a_if.tick = 1'b0;
      flags_a($sformatf("t2.tick%0d", i), 8 - i, i != 8, i != 8, i == 8, i == 8);
    end

    // Saturating bonus with a simultaneous tick
    do_reset();
    a_if.load = 1'b1; a_if.load_val = 8'd250; cycle(); a_if.load = 1'b0;
    a_if.start = 1'b1; cycle(); a_if.start = 1'b0;
    a_if.add = 1'b1; a_if.add_val = 8'd20; a_if.tick = 1'b1; cycle();
    a_if.add = 1'b0; a_if.tick = 1'b0;
    flags_a("t3.sat", 254, 1, 0, 0, 0);

    // Back-to-back ticks to 30, then lose, second lose, restart
    do_reset();
    a_if.start = 1'b1; cycle(); a_if.start = 1'b0;
    a_if.tick = 1'b1;
    repeat (29) cycle();
    a_if.tick = 1'b0;
    flags_a("t5.at30", 30, 1, 0, 0, 0);
    a_if.lose = 1'b1; cycle(); a_if.lose = 1'b0;
    flags_a("t5.lose", 0, 0, 0, 1, 1);
    a_if.lose = 1'b1; cycle(); a_if.lose = 1'b0;
    flags_a("t5.lose2", 0, 0, 0, 1, 0);
    a_if.start = 1'b1; cycle(); a_if.start = 1'b0;
    flags_a("t5.restart", 59, 1, 0, 0, 0);

    // Reset in the middle of a run at 17, with a tick on the same edge
    a_if.tick = 1'b1;
    repeat (42) cycle();
    flags_a("t6.at17", 17, 1, 0, 0, 0);
    rst = 1'b0; cycle(); rst = 1'b1;
    flags_a("t6.reset", 59, 0, 0, 0, 0);
    repeat (3) cycle();
    a_if.tick = 1'b0;
    flags_a("t6.idle_ticks", 59, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
